// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: arbitrates fetch vs. data requests, loads the MAR,
// runs the read/write handshake with a wait-cycle timeout and pulses the completion strobes.
module mem_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic fetch_req_i,
    input  logic data_req_i,
    input  logic data_we_i,
    input  logic mem_ready_i,
    output logic addr_sel_o,
    output logic mar_load_o,
    output logic mem_rd_o,
    output logic mem_wr_o,
    output logic ir_load_o,
    output logic mdr_load_o,
    output logic pc_inc_o,
    output logic fetch_done_o,
    output logic data_done_o,
    output logic busy_o,
    output logic timeout_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_MAR,
        ACCESS,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mar_load_q, mar_load_d;
    logic mem_rd_q, mem_rd_d;
    logic mem_wr_q, mem_wr_d;
    logic ir_load_q, ir_load_d;
    logic mdr_load_q, mdr_load_d;
    logic pc_inc_q, pc_inc_d;
    logic fetch_done_q, fetch_done_d;
    logic data_done_q, data_done_d;
    logic busy_q, busy_d;
    logic access_limit;

    // The abort decision depends on mem_ready in the very cycle the limit is hit.
    assign access_limit = (state_q == ACCESS) && (cnt_q == CNT_LIMIT) && !mem_ready_i;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    grant_d = 1'b1;
                    we_d    = data_we_i;
                    state_d = LOAD_MAR;
                end else if (fetch_req_i) begin
                    grant_d = 1'b0;
                    we_d    = 1'b0;
                    state_d = LOAD_MAR;
                end
            end
            LOAD_MAR: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (mem_ready_i) begin
                    state_d = DONE;
                end else if (access_limit) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        mar_load_d   = (state_d == LOAD_MAR);
        mem_rd_d     = (state_d == ACCESS) && !we_d;
        mem_wr_d     = (state_d == ACCESS) && we_d;
        ir_load_d    = (state_d == DONE) && !grant_d;
        pc_inc_d     = (state_d == DONE) && !grant_d;
        fetch_done_d = (state_d == DONE) && !grant_d;
        mdr_load_d   = (state_d == DONE) && grant_d && !we_d;
        data_done_d  = (state_d == DONE) && grant_d;
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mar_load_q   <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            ir_load_q    <= 1'b0;
            mdr_load_q   <= 1'b0;
            pc_inc_q     <= 1'b0;
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            mar_load_q   <= mar_load_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            ir_load_q    <= ir_load_d;
            mdr_load_q   <= mdr_load_d;
            pc_inc_q     <= pc_inc_d;
            fetch_done_q <= fetch_done_d;
            data_done_q  <= data_done_d;
            busy_q       <= busy_d;
        end
    end

    assign addr_sel_o    = grant_q;
    assign mar_load_o    = mar_load_q;
    assign mem_rd_o      = mem_rd_q;
    assign mem_wr_o      = mem_wr_q;
    assign ir_load_o     = ir_load_q;
    assign mdr_load_o    = mdr_load_q;
    assign pc_inc_o      = pc_inc_q;
    assign fetch_done_o  = fetch_done_q;
    assign data_done_o   = data_done_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = access_limit;

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sequences every memory access in the 16-bit processor: owns the address mux select, the MAR load strobe and the memory read/write handshake.
- Arbitrates between the control unit's instruction-fetch request and its data (load/store) request.
- Steers the PC (select 0) or the data bus (select 1) into the MAR, runs the access, then pulses the IR/MDR/PC strobes.

Parameters:
TIMEOUT_CYCLES, 15, max ACCESS cycles without mem_ready before abort (1..255)
CNT_W, 8, width of wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
fetch_req  in  1  level request: instruction fetch at PC
data_req  in  1  level request: data access at data-bus address
data_we  in  1  data access direction (1=write); sampled at grant
mem_ready  in  1  memory completion, sampled in ACCESS
addr_sel  out  1  address mux select: 0=PC, 1=data bus
mar_load  out  1  MAR load strobe
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable
ir_load  out  1  instruction register load strobe
mdr_load  out  1  memory data register load strobe
pc_inc  out  1  program counter increment strobe
fetch_done  out  1  fetch complete pulse
data_done  out  1  data access complete pulse
busy  out  1  high in any state except IDLE
timeout_err  out  1  one-cycle pulse on aborted access

Behaviour:
- Reset (async, rst=1): state=IDLE; grant register, we register and wait counter cleared; all outputs 0, including addr_sel=0. Reset mid-access drops mem_rd/mem_wr immediately; the transaction is abandoned and no done pulse is issued.
- Outputs are Moore outputs decoded from registered state. addr_sel comes from the grant register and holds its value until the next grant.
- States: IDLE, LOAD_MAR, ACCESS, DONE.
- IDLE:
  - data_req=1 -> grant=data (addr_sel<=1), latch data_we.
  - Else fetch_req=1 -> grant=fetch (addr_sel<=0), we<=0.
  - Either grant -> LOAD_MAR. Neither -> stay.
  - Fixed priority: data beats fetch when both are asserted in the same cycle.
- LOAD_MAR: mar_load=1 for exactly one cycle; addr_sel is already stable from the previous edge; wait counter<=0; -> ACCESS.
- ACCESS:
  - mem_rd=1 when we=0; mem_wr=1 when we=1.
  - mem_ready=1 -> DONE.
  - Else counter+1. If counter reaches TIMEOUT_CYCLES-1 with mem_ready=0 -> IDLE, with timeout_err=1 for one cycle (asserted in the ACCESS cycle where the limit is hit).
  - mem_ready takes precedence over timeout in the same cycle.
- DONE, one cycle:
  - Fetch: ir_load=1, pc_inc=1, fetch_done=1.
  - Data read: mdr_load=1, data_done=1.
  - Data write: data_done=1 only.
  - -> IDLE.
- Latency with zero-wait memory: grant edge -> LOAD_MAR (cycle 1) -> ACCESS (cycle 2) -> DONE (cycle 3) -> IDLE (cycle 4). Four cycles per access; next grant earliest in cycle 4.
- Requests:
  - Level-sensitive, sampled only in IDLE.
  - Deassertion after grant has no effect; the access completes.
  - A requester still asserting in IDLE after its done pulse is served again; the requester must drop its request on done.
  - data_we changes after grant are ignored.
- mem_ready outside ACCESS is ignored.
- No two of mar_load, mem_rd/mem_wr, or the DONE strobes are ever high in the same cycle.

Test Plan:
- Reset, fetch_req=1, mem_ready tied 1 -> mar_load in cycle 1 with addr_sel=0; mem_rd cycle 2; ir_load+pc_inc+fetch_done cycle 3; busy=0 cycle 4.
- fetch_req=1 and data_req=1 together, data_we=0 -> data served first (addr_sel=1, mdr_load+data_done); fetch granted in the following IDLE (addr_sel=0).
- data_req=1, data_we=1, mem_ready delayed 3 cycles -> mem_wr high for 4 ACCESS cycles; data_done only, with no mdr_load/ir_load/pc_inc.
- TIMEOUT_CYCLES=4, fetch_req=1, mem_ready=0 -> mem_rd high 4 cycles; timeout_err pulses in the 4th; return to IDLE; no fetch_done/ir_load.
- Assert rst during ACCESS (mem_rd=1) -> mem_rd, busy and addr_sel go 0 without waiting for a clock edge; after release, IDLE and a fresh grant works.
- Drop data_req in LOAD_MAR; pulse mem_ready in IDLE -> access still completes with data_done; the stray mem_ready causes no state change.
